// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared constants for the UART APB controller.
//   - register offsets (word index from PADDR[3:2])
//   - STATUS bit positions
//   - FSM state encoding
//   - default baud divisor
package uart_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;  // 0x0
  localparam logic [1:0] REG_STATUS = 2'd1;  // 0x4
  localparam logic [1:0] REG_BAUD   = 2'd2;  // 0x8
  localparam logic [1:0] REG_IER    = 2'd3;  // 0xC

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_RX_EMPTY   = 1;
  localparam int STAT_TX_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [10:0] BAUD_RESET_DEFAULT = 11'd650;

endpackage

// File: rtl/uart_ctrl_regs.sv
// uart_ctrl_regs: BAUD divisor, TX-timeout sticky flag, IER and read mux.
// Optional feature macro: UART_CTRL_IRQ_EN (adds IER storage and irq_o).
// Ports:
//   clk_i, reset_ni      clock, synchronous active-low reset
//   we_i, sel_i, wdata_i register write strobe, register select, write data
//   timeout_set_i        sets the sticky TX-timeout flag (wins over clear)
//   tx_full_i, rx_empty_i live FIFO flags for STATUS / irq
//   rdata_o              combinational read data for sel_i
//   wr_err_o             write to sel_i with wdata_i would be rejected
//   baud_o               baud divisor
//   irq_o                registered interrupt (macro only)
module uart_ctrl_regs
  import uart_ctrl_pkg::*;
#(
  parameter logic [10:0] BAUD_RESET = BAUD_RESET_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [10:0] wdata_i,
  input  logic        timeout_set_i,
  input  logic        tx_full_i,
  input  logic        rx_empty_i,
  output logic [31:0] rdata_o,
  output logic        wr_err_o,
  output logic [10:0] baud_o
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  logic [10:0] baud_q;
  logic        sticky_q;

  // A zero divisor would stall the baud generator, so it is refused.
  assign wr_err_o = (sel_i == REG_BAUD) && (wdata_i == 11'd0);
  assign baud_o   = baud_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      baud_q   <= BAUD_RESET;
      sticky_q <= 1'b0;
    end else begin
      if (we_i && (sel_i == REG_BAUD) && (wdata_i != 11'd0)) begin
        baud_q <= wdata_i;
      end
      if (timeout_set_i) begin
        sticky_q <= 1'b1;
      end else if (we_i && (sel_i == REG_STATUS) && wdata_i[STAT_TX_TIMEOUT]) begin
        sticky_q <= 1'b0;
      end
    end
  end

`ifdef UART_CTRL_IRQ_EN
  logic [1:0] ier_q;
  logic       irq_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ier_q <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (we_i && (sel_i == REG_IER)) begin
        ier_q <= wdata_i[1:0];
      end
      irq_q <= (ier_q[0] & ~rx_empty_i) | (ier_q[1] & ~tx_full_i);
    end
  end

  assign irq_o = irq_q;
`endif

  always_comb begin
    rdata_o = 32'd0;
    case (sel_i)
      REG_STATUS: begin
        rdata_o[STAT_TX_FULL]    = tx_full_i;
        rdata_o[STAT_RX_EMPTY]   = rx_empty_i;
        rdata_o[STAT_TX_TIMEOUT] = sticky_q;
      end
      REG_BAUD: rdata_o = {21'd0, baud_q};
`ifdef UART_CTRL_IRQ_EN
      REG_IER:  rdata_o = {30'd0, ier_q};
`endif
      default:  rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB3 slave that sets the UART baud divisor, pushes bytes
// into the TX FIFO (bounded stall while full) and pops the RX FIFO on
// DATA reads.
// Optional feature macro: UART_CTRL_IRQ_EN (adds the irq output and IER).
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   PSEL..PWDATA               APB request
//   PRDATA, PREADY, PSLVERR    APB response, all registered
//   baud_final_value           divisor to the baud generator
//   tx_fifo_dataIn/writeEn     TX FIFO push (one-cycle pulse)
//   tx_fifo_Full               TX FIFO full
//   rx_fifo_readEn             RX FIFO pop (one-cycle pulse)
//   rx_fifo_Empty/dataOut      RX FIFO status and head byte
//   irq                        interrupt (macro only)
//
// state   | meaning
// IDLE    | waiting for an APB setup phase
// DECODE  | first access cycle, performs the access or starts a TX stall
// WAIT_TX | TX FIFO full, counting wait states toward timeout
// RESP    | PREADY high for one cycle, strobe pulse coincident
module uart_apb_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [10:0] BAUD_RESET = BAUD_RESET_DEFAULT,
  parameter int          TX_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [10:0]       baud_final_value,
  output logic [7:0]        tx_fifo_dataIn,
  output logic              tx_fifo_writeEn,
  input  logic              tx_fifo_Full,
  output logic              rx_fifo_readEn,
  input  logic              rx_fifo_Empty,
  input  logic [7:0]        rx_fifo_dataOut
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CNT_W = (TX_TIMEOUT > 2) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  state_e            state_q;
  logic [ADDR_W-3:0] addr_q;   // PADDR[ADDR_W-1:2]
  logic              write_q;
  logic [10:0]       wdata_q;  // no register uses more than 11 bits
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       prdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic              tx_we_q;
  logic              rx_re_q;
  logic [7:0]        tx_data_q;

  logic        addr_ok;
  logic [1:0]  reg_sel;
  logic        reg_we;
  logic        reg_err;
  logic [31:0] reg_rdata;
  logic        timeout_hit;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:11]};
  assign reg_sel     = addr_q[1:0];

  if (ADDR_W > 4) begin : g_hi_addr
    assign addr_ok = (addr_q[ADDR_W-3:2] == '0);
  end else begin : g_no_hi_addr
    assign addr_ok = 1'b1;
  end

  // Register side effects happen on the DECODE edge only, and never for an
  // aborted transfer or an out-of-range address.
  assign reg_we = (state_q == ST_DECODE) && PSEL && addr_ok && write_q &&
                  (reg_sel != REG_DATA);

  assign timeout_hit = (state_q == ST_WAIT_TX) && PSEL && tx_fifo_Full &&
                       (cnt_q == CNT_LAST);

  uart_ctrl_regs #(
    .BAUD_RESET(BAUD_RESET)
  ) u_regs (
    .clk_i         (clk),
    .reset_ni      (reset),
    .we_i          (reg_we),
    .sel_i         (reg_sel),
    .wdata_i       (wdata_q),
    .timeout_set_i (timeout_hit),
    .tx_full_i     (tx_fifo_Full),
    .rx_empty_i    (rx_fifo_Empty),
    .rdata_o       (reg_rdata),
    .wr_err_o      (reg_err),
    .baud_o        (baud_final_value)
`ifdef UART_CTRL_IRQ_EN
    ,
    .irq_o         (irq)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tx_we_q   <= 1'b0;
      rx_re_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_we_q <= 1'b0;
      rx_re_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR[ADDR_W-1:2];
            write_q <= PWRITE;
            wdata_q <= PWDATA[10:0];
            state_q <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          cnt_q <= '0;
          if (!PSEL) begin
            state_q <= ST_IDLE;
          end else if (!addr_ok) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
            pready_q  <= 1'b1;
            state_q   <= ST_RESP;
          end else if (reg_sel == REG_DATA) begin
            if (write_q) begin
              if (tx_fifo_Full) begin
                state_q <= ST_WAIT_TX;
              end else begin
                tx_data_q <= wdata_q[7:0];
                tx_we_q   <= 1'b1;
                prdata_q  <= '0;
                pready_q  <= 1'b1;
                state_q   <= ST_RESP;
              end
            end else begin
              prdata_q  <= rx_fifo_Empty ? 32'd0 : {24'd0, rx_fifo_dataOut};
              rx_re_q   <= !rx_fifo_Empty;
              pslverr_q <= rx_fifo_Empty;
              pready_q  <= 1'b1;
              state_q   <= ST_RESP;
            end
          end else begin
            prdata_q  <= write_q ? 32'd0 : reg_rdata;
            pslverr_q <= write_q && reg_err;
            pready_q  <= 1'b1;
            state_q   <= ST_RESP;
          end
        end

        ST_WAIT_TX: begin
          if (!PSEL) begin
            state_q <= ST_IDLE;
          end else if (!tx_fifo_Full) begin
            tx_data_q <= wdata_q[7:0];
            tx_we_q   <= 1'b1;
            prdata_q  <= '0;
            pready_q  <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b1;
            pready_q  <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PRDATA          = prdata_q;
  assign PREADY          = pready_q;
  assign PSLVERR         = pslverr_q;
  assign tx_fifo_writeEn = tx_we_q;
  assign rx_fifo_readEn  = rx_re_q;
  assign tx_fifo_dataIn  = tx_data_q;

endmodule

// File: doc/uart_apb_ctrl.md
Name: uart_apb_ctrl

Overview:
APB3 slave that configures and sequences the UART block, exposing it to the bus through a small register map.
- Drives the baud divisor.
- Pushes bytes into the TX FIFO with a bounded stall while the FIFO is full.
- Pops bytes from the RX FIFO on data-register reads.
- Sits between the APB bridge and the UART controller, one instance per UART.

Parameters:
- ADDR_W, 12: PADDR width; must be ≥ 4.
- BAUD_RESET, 11'd650: baud_final_value after reset.
- TX_TIMEOUT, 1024: maximum wait-state cycles on a full TX FIFO before error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction (1 = write).
- PADDR  in  ADDR_W  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data, registered.
- PREADY  out  1  APB ready, registered.
- PSLVERR  out  1  APB error, valid only while PREADY=1.
- baud_final_value  out  11  divisor to the baud generator.
- tx_fifo_dataIn  out  8  byte to the TX FIFO.
- tx_fifo_writeEn  out  1  one-cycle TX push pulse.
- tx_fifo_Full  in  1  TX FIFO full.
- rx_fifo_readEn  out  1  one-cycle RX pop pulse.
- rx_fifo_Empty  in  1  RX FIFO empty.
- rx_fifo_dataOut  in  8  RX FIFO head byte, valid while not empty.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State IDLE; PRDATA=0, PREADY=0, PSLVERR=0, tx_fifo_writeEn=0, rx_fifo_readEn=0, tx_fifo_dataIn=0.
  - baud_final_value=BAUD_RESET; sticky timeout flag=0; wait counter=0.
  - Reset mid-transfer aborts the transfer with no pulse issued.
- Register map, decoded on PADDR[3:2]; any nonzero PADDR[ADDR_W-1:4] gives PSLVERR=1 with no side effect.
  - 0x0 DATA: write pushes PWDATA[7:0]; read pops one byte into PRDATA[7:0].
  - 0x4 STATUS: bit0 tx_fifo_Full, bit1 rx_fifo_Empty, bit2 tx_timeout sticky. Writing 1 to bit2 clears it; other bits are ignored.
  - 0x8 BAUD: RW, bits[10:0]. A write of 0 gives PSLVERR=1 and the old value is kept. Upper bits are ignored and read as 0.
  - 0xC IER: see Optional Feature.
- FSM states: IDLE, DECODE, WAIT_TX, RESP.
  - IDLE: on PSEL=1 and PENABLE=0, latch PADDR, PWRITE and PWDATA, then go to DECODE.
  - DECODE (first access cycle, PREADY=0):
    - DATA write with tx_fifo_Full=0: register tx_fifo_dataIn, set tx_fifo_writeEn=1 for the next cycle, go to RESP.
    - DATA write with tx_fifo_Full=1: counter=0, go to WAIT_TX.
    - DATA read with rx_fifo_Empty=0: PRDATA={24'b0, rx_fifo_dataOut}, set rx_fifo_readEn=1 for the next cycle, go to RESP.
    - DATA read with rx_fifo_Empty=1: PRDATA=0, PSLVERR=1, no pop, go to RESP.
    - Any other register: perform the access, go to RESP.
  - WAIT_TX:
    - tx_fifo_Full=0: push as in DECODE, go to RESP.
    - Otherwise increment the counter. When counter==TX_TIMEOUT-1: PSLVERR=1, set the sticky flag, no push, go to RESP.
  - RESP: PREADY=1 for exactly one cycle, then IDLE. The strobe pulse is coincident with PREADY.
- Latency: PREADY is high in the 2nd access cycle (one wait state) in the no-stall case. Worst case on a full TX FIFO is TX_TIMEOUT+1 wait states.
- Pulses:
  - tx_fifo_writeEn and rx_fifo_readEn are at most one cycle each, never both high together, and at most one per transfer.
- Abort: PSEL=0 in DECODE or WAIT_TX returns to IDLE with no pulse and PREADY=0.
- Simultaneous events: a write clearing the sticky bit in the same cycle a timeout sets it leaves the bit set (set wins).
- Back-to-back transfers: a new setup phase is accepted in the cycle after RESP.

Optional Feature:
- Macro: UART_CTRL_IRQ_EN.
- Defined:
  - Extra port irq (out, 1, registered, reset 0).
  - IER at 0xC is RW, bits[1:0], reset 0. Bit0 enables RX-not-empty; bit1 enables TX-not-full.
  - irq <= (IER[0] & ~rx_fifo_Empty) | (IER[1] & ~tx_fifo_Full), updated every cycle.
- Undefined:
  - No irq port. 0xC reads as 0; writes are ignored with no error.

Decomposition:
- Package/header uart_ctrl_pkg holds:
  - register offsets (DATA, STATUS, BAUD, IER);
  - STATUS bit positions;
  - FSM state encoding (2 bits);
  - default BAUD_RESET constant.
- One natural sub-module: uart_ctrl_regs, covering BAUD, sticky flag, IER and read mux. The FSM and strobes stay in the top.

Test Plan:
- Reset, then read 0x8 → PRDATA=650, PSLVERR=0; read 0x4 with FIFOs idle (Full=0, Empty=1) → PRDATA=0x2.
- Write 0x0 data 0xA5 with Full=0 → tx_fifo_writeEn high one cycle with tx_fifo_dataIn=0xA5, coincident with PREADY in the 2nd access cycle.
- Read 0x0 with Empty=0, dataOut=0x3C → PRDATA=0x3C, one rx_fifo_readEn pulse. Repeat with Empty=1 → PRDATA=0, PSLVERR=1, no pulse.
- Write 0x0 with Full held 1 for 10 cycles → 11 wait states then push. With Full held 1 permanently and TX_TIMEOUT=16 → PSLVERR=1 after 17 wait states, no push, STATUS bit2=1; write 0x4 with 0x4 → bit2=0.
- Write 0x8 with 0 → PSLVERR=1, BAUD unchanged. Write 0x8 with 0x145 → baud_final_value=0x145. Access 0x10 → PSLVERR=1.
- UART_CTRL_IRQ_EN: write IER=1, then Empty 1→0 → irq=1 one cycle later.
- Reset asserted in WAIT_TX → no push, all outputs return to reset values.
